maq_refri_ctrl: RTL and testbench
=================================

# maq_refri_ctrl

Multi-product vending sales controller that sits between the coin acceptor and the dispense and change mechanisms of the soft-drink machine. It does four things:
- accumulates credit from 5/10/25-cent coins and rejects coins that would overflow the credit limit;
- arbitrates product selection against four configurable prices;
- sequences the dispenser through a req/ack handshake;
- returns change one coin at a time, greedy, through a second req/ack handshake.

## Interface

Parameters:
- PRICE0, default 20: price of product 0, in cents.
- PRICE1, default 25: price of product 1.
- PRICE2, default 35: price of product 2.
- PRICE3, default 50: price of product 3.
- CREDIT_MAX, default 95: maximum credit held.
- Constraints: all values are multiples of 5, every PRICEn ≤ CREDIT_MAX, and CREDIT_MAX ≤ 100.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- moeda  in  2  coin code, one cycle per coin: 00 none, 01 = 5, 10 = 10, 11 = 25.
- sel_vld  in  1  product request strobe.
- sel  in  2  product index, valid while sel_vld is high.
- cancel  in  1  request refund of the current credit.
- disp_req  out  1  dispense request.
- disp_id  out  2  product being dispensed.
- disp_ack  in  1  dispenser acknowledge.
- chg_req  out  1  change-coin request.
- chg_coin  out  2  coin to eject, same encoding as moeda.
- chg_ack  in  1  coin ejector acknowledge.
- coin_rej  out  1  one-cycle pulse: the sampled coin is returned uncredited.
- sel_err  out  1  one-cycle pulse: credit is insufficient for the selection.
- credit  out  7  current credit in cents.
- busy  out  1  high in DISPENSE or CHANGE.

## Operation

States: IDLE, CREDIT, DISPENSE, CHANGE.

**IDLE** (credit = 0):
- An accepted coin adds its value to credit and moves to CREDIT.
- sel_vld raises sel_err.
- cancel is ignored.

**CREDIT:**
- Priority in a cycle is cancel > sel_vld > coin.
- cancel: go to CHANGE.
- sel_vld with credit ≥ PRICE[sel]: set credit = credit − PRICE[sel], latch disp_id = sel, assert disp_req, go to DISPENSE.
- sel_vld with credit < PRICE[sel]: pulse sel_err, stay in CREDIT, and process any coin in the same cycle normally.
- A coin sampled in the same cycle as an acted-upon cancel or successful selection is rejected (coin_rej).
- Coin acceptance: accept only if credit + value ≤ CREDIT_MAX. Otherwise pulse coin_rej and leave credit unchanged.

**DISPENSE:**
- disp_req and disp_id are held stable until disp_ack is sampled high.
- After disp_ack: go to CHANGE if credit > 0, else IDLE.
- Coins are rejected. sel_vld and cancel are ignored.

**CHANGE:**
- chg_req is high and chg_coin is chosen greedy from credit: 11 if credit ≥ 25, 10 if credit ≥ 10, else 01.
- On chg_ack: credit is reduced by the coin value, and the next coin is presented the following cycle.
- When credit reaches 0: go to IDLE.
- Coins are rejected. sel_vld and cancel are ignored.

**General rules:**
- disp_ack and chg_ack sampled while the corresponding req is low are ignored.
- Arithmetic is 7-bit unsigned. The sum is compared before update, so credit never exceeds CREDIT_MAX and never underflows.
- Reset, including mid-operation: state IDLE, credit 0, and all outputs 0 on the next edge. Any pending credit is forfeited.

## Timing

- All outputs are registered.
- A coin at edge n is reflected in credit (or coin_rej) at n+1.
- sel_vld at n: disp_req, disp_id and the reduced credit appear at n+1. On failure, sel_err appears at n+1 for exactly one cycle.
- disp_ack high at edge m: disp_req is low at m+1. chg_req is high at m+1 if change is due.
- chg_ack at edge k: credit and chg_coin are updated at k+1. chg_req is low at k+1 only if credit has reached 0.
- With chg_ack held high, exactly one coin is ejected per cycle.
- busy follows state with one cycle of latency from the transition edge.

## Test plan

1. Reset, then coins 01, 10, 10, then sel=0 → credit goes 5, 15, 25. disp_req=1 with disp_id=0 and credit 5. After disp_ack, chg_req=1 with chg_coin=01. After chg_ack, credit 0, state IDLE, busy 0.
2. Coin 11, then sel=2 → sel_err pulses once and credit stays 25. Then coin 10 and sel=2 → dispense with disp_id=2, credit 0, no chg_req after disp_ack.
3. Coin 11 three times (credit 75), then coin 11 → coin_rej pulses and credit stays 75. Then coin 10 → credit 85. Then cancel → chg_coin sequence 11, 11, 11, 10 with chg_ack held high, giving four consecutive cycles and credit 0.
4. During DISPENSE, insert coin 10 and delay disp_ack 5 cycles → coin_rej pulses, credit is unchanged, and disp_req/disp_id are held stable for all 5 cycles.
5. Assert rst in the middle of CHANGE → next cycle credit 0, chg_req 0, IDLE. A following chg_ack causes no change.
6. Credit 25: sel_vld=1 (sel=0) together with coin 01 → dispense and coin_rej. Separately, cancel together with sel_vld → CHANGE and no disp_req.

Source files
------------

// File: rtl/maq_refri_ctrl.sv
// Soft-drink sales controller: coin credit, priced product selection, dispense
// handshake, and greedy one-coin-at-a-time change return.
module maq_refri_ctrl #(
  parameter int unsigned PRICE0     = 20,
  parameter int unsigned PRICE1     = 25,
  parameter int unsigned PRICE2     = 35,
  parameter int unsigned PRICE3     = 50,
  parameter int unsigned CREDIT_MAX = 95
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] moeda,
  input  logic       sel_vld,
  input  logic [1:0] sel,
  input  logic       cancel,
  output logic       disp_req,
  output logic [1:0] disp_id,
  input  logic       disp_ack,
  output logic       chg_req,
  output logic [1:0] chg_coin,
  input  logic       chg_ack,
  output logic       coin_rej,
  output logic       sel_err,
  output logic [6:0] credit,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, CREDIT, DISPENSE, CHANGE} state_t;

  state_t     state_q, state_d;
  logic [6:0] credit_q, credit_d;
  logic [1:0] disp_id_q, disp_id_d;
  logic [1:0] chg_coin_q, chg_coin_d;
  logic       disp_req_q, disp_req_d;
  logic       chg_req_q, chg_req_d;
  logic       coin_rej_q, coin_rej_d;
  logic       sel_err_q, sel_err_d;
  logic       busy_q, busy_d;

  logic [6:0] coin_v, price;
  logic [7:0] sum;
  logic       take_coin;

  function automatic logic [6:0] coin_val(input logic [1:0] c);
    case (c)
      2'b01:   coin_val = 7'd5;
      2'b10:   coin_val = 7'd10;
      2'b11:   coin_val = 7'd25;
      default: coin_val = 7'd0;
    endcase
  endfunction

  function automatic logic [1:0] greedy(input logic [6:0] cr);
    if (cr >= 7'd25)      greedy = 2'b11;
    else if (cr >= 7'd10) greedy = 2'b10;
    else                  greedy = 2'b01;
  endfunction

  always_comb begin
    case (sel)
      2'd0:    price = 7'(PRICE0);
      2'd1:    price = 7'(PRICE1);
      2'd2:    price = 7'(PRICE2);
      default: price = 7'(PRICE3);
    endcase
  end

  assign coin_v = coin_val(moeda);
  // Compared in 8 bits so the limit check cannot wrap.
  assign sum    = {1'b0, credit_q} + {1'b0, coin_v};

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    disp_id_d  = disp_id_q;
    coin_rej_d = 1'b0;
    sel_err_d  = 1'b0;
    take_coin  = 1'b0;
    case (state_q)
      IDLE: begin
        sel_err_d = sel_vld;
        take_coin = 1'b1;
      end
      CREDIT: begin
        if (cancel) begin
          state_d    = (credit_q != 7'd0) ? CHANGE : IDLE;
          coin_rej_d = |moeda;
        end else if (sel_vld && credit_q >= price) begin
          credit_d   = credit_q - price;
          disp_id_d  = sel;
          state_d    = DISPENSE;
          coin_rej_d = |moeda;
        end else begin
          sel_err_d = sel_vld;
          take_coin = 1'b1;
        end
      end
      DISPENSE: begin
        coin_rej_d = |moeda;
        if (disp_ack) state_d = (credit_q != 7'd0) ? CHANGE : IDLE;
      end
      default: begin
        coin_rej_d = |moeda;
        // chg_coin_q is the coin actually presented to the ejector.
        if (chg_ack) begin
          credit_d = credit_q - coin_val(chg_coin_q);
          if (credit_d == 7'd0) state_d = IDLE;
        end
      end
    endcase
    if (take_coin && moeda != 2'b00) begin
      if (sum <= 8'(CREDIT_MAX)) begin
        credit_d = sum[6:0];
        state_d  = CREDIT;
      end else begin
        coin_rej_d = 1'b1;
      end
    end
    disp_req_d = (state_d == DISPENSE);
    chg_req_d  = (state_d == CHANGE);
    chg_coin_d = chg_req_d ? greedy(credit_d) : 2'b00;
    busy_d     = disp_req_d | chg_req_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      credit_q   <= '0;
      disp_id_q  <= '0;
      chg_coin_q <= '0;
      disp_req_q <= 1'b0;
      chg_req_q  <= 1'b0;
      coin_rej_q <= 1'b0;
      sel_err_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      disp_id_q  <= disp_id_d;
      chg_coin_q <= chg_coin_d;
      disp_req_q <= disp_req_d;
      chg_req_q  <= chg_req_d;
      coin_rej_q <= coin_rej_d;
      sel_err_q  <= sel_err_d;
      busy_q     <= busy_d;
    end
  end

  assign credit   = credit_q;
  assign disp_req = disp_req_q;
  assign disp_id  = disp_id_q;
  assign chg_req  = chg_req_q;
  assign chg_coin = chg_coin_q;
  assign coin_rej = coin_rej_q;
  assign sel_err  = sel_err_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_maq_refri_ctrl.sv
// Directed plan scenarios plus random traffic, every cycle compared against a
// transaction-level vending model.
module tb_maq_refri_ctrl;

  localparam int CMAX = 95;
  int price [4] = '{20, 25, 35, 50};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] moeda = 2'b00;
  logic       sel_vld = 1'b0;
  logic [1:0] sel = 2'b00;
  logic       cancel = 1'b0;
  logic       disp_ack = 1'b0;
  logic       chg_ack = 1'b0;
  logic       disp_req, chg_req, coin_rej, sel_err, busy;
  logic [1:0] disp_id, chg_coin;
  logic [6:0] credit;

  always #5 clk = ~clk;

  maq_refri_ctrl dut (
    .clk(clk), .rst(rst), .moeda(moeda), .sel_vld(sel_vld), .sel(sel),
    .cancel(cancel), .disp_req(disp_req), .disp_id(disp_id),
    .disp_ack(disp_ack), .chg_req(chg_req), .chg_coin(chg_coin),
    .chg_ack(chg_ack), .coin_rej(coin_rej), .sel_err(sel_err),
    .credit(credit), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 holding credit, 2 dispensing, 3 returning change.
  int m_mode = 0, m_cr = 0, m_id = 0;
  bit m_rej = 0, m_err = 0;

  function automatic int cval(input int c);
    return (c == 1) ? 5 : (c == 2) ? 10 : (c == 3) ? 25 : 0;
  endfunction

  function automatic int gcoin(input int cr);
    return (cr >= 25) ? 3 : (cr >= 10) ? 2 : 1;
  endfunction

  task automatic model_edge();
    int v;
    v = cval(int'(moeda));
    m_rej = 0;
    m_err = 0;
    if (rst) begin
      m_mode = 0; m_cr = 0;
      return;
    end
    case (m_mode)
      0, 1: begin
        if (m_mode == 1 && cancel) begin
          m_mode = 3; m_rej = (v != 0);
        end else if (m_mode == 1 && sel_vld && m_cr >= price[sel]) begin
          m_cr -= price[sel]; m_id = int'(sel); m_mode = 2; m_rej = (v != 0);
        end else begin
          m_err = sel_vld;
          if (v != 0) begin
            if (m_cr + v <= CMAX) begin m_cr += v; m_mode = 1; end
            else m_rej = 1;
          end
        end
      end
      2: begin
        m_rej = (v != 0);
        if (disp_ack) m_mode = (m_cr > 0) ? 3 : 0;
      end
      default: begin
        m_rej = (v != 0);
        if (chg_ack) begin
          m_cr -= cval(gcoin(m_cr));
          if (m_cr == 0) m_mode = 0;
        end
      end
    endcase
  endtask

  task automatic compare();
    chk("credit", int'(credit), m_cr);
    chk("disp_req", int'(disp_req), int'(m_mode == 2));
    if (m_mode == 2) chk("disp_id", int'(disp_id), m_id);
    chk("chg_req", int'(chg_req), int'(m_mode == 3));
    if (m_mode == 3) chk("chg_coin", int'(chg_coin), gcoin(m_cr));
    chk("coin_rej", int'(coin_rej), int'(m_rej));
    chk("sel_err", int'(sel_err), int'(m_err));
    chk("busy", int'(busy), int'(m_mode >= 2));
  endtask

  task automatic step(input bit r, input int m, input bit sv, input int s,
                      input bit cn, input bit da, input bit ca);
    @(negedge clk);
    rst = r; moeda = 2'(m); sel_vld = sv; sel = 2'(s);
    cancel = cn; disp_ack = da; chg_ack = ca;
    @(posedge clk);
    model_edge();
    #1 compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("reset_credit", int'(credit), 0);
    // 1: 5+10+10 then product 0, change of one nickel
    step(0, 1, 0, 0, 0, 0, 0); step(0, 2, 0, 0, 0, 0, 0); step(0, 2, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    chk("t1_disp_credit", int'(credit), 5);
    idle(2);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("t1_chg_coin", int'(chg_coin), 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("t1_busy", int'(busy), 0);
    // 2: insufficient then exact credit for product 2
    step(0, 3, 0, 0, 0, 0, 0); step(0, 0, 1, 2, 0, 0, 0); idle(1);
    step(0, 2, 0, 0, 0, 0, 0); step(0, 0, 1, 2, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0); idle(1);
    // 3: overflow reject, then cancel with ack held
    step(0, 3, 0, 0, 0, 0, 0); step(0, 3, 0, 0, 0, 0, 0); step(0, 3, 0, 0, 0, 0, 0);
    step(0, 3, 0, 0, 0, 0, 0);
    chk("t3_overflow_rej", int'(coin_rej), 1);
    step(0, 2, 0, 0, 0, 0, 0); step(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1);
    chk("t3_empty", int'(chg_req), 0);
    idle(1);
    // 4: coin during a slow dispense
    step(0, 3, 0, 0, 0, 0, 0); step(0, 0, 1, 1, 0, 0, 0);
    step(0, 2, 0, 0, 0, 0, 0); idle(4);
    step(0, 0, 0, 0, 0, 1, 0); idle(1);
    // 5: reset mid change, stray ack afterwards
    step(0, 3, 0, 0, 0, 0, 0); step(0, 2, 0, 0, 0, 0, 0); step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1); step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1); step(0, 0, 0, 0, 0, 1, 0);
    // 6: select with coin, then cancel beats select
    step(0, 3, 0, 0, 0, 0, 0); step(0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0); step(0, 0, 0, 0, 0, 0, 1);
    step(0, 3, 0, 0, 0, 0, 0); step(0, 0, 1, 0, 1, 0, 0);
    chk("t6_no_disp", int'(disp_req), 0);
    step(0, 0, 0, 0, 0, 0, 1);
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0,
           ($urandom_range(0, 5) == 0), int'($urandom_range(0, 3)),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
